// File: rtl/interleaver_sequencer_pkg.sv
// Shared types and width derivations for the interleaver sequencer slice.
package interleaver_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } seq_state_t;

  // Width of cycle_index: one index per z-wide slice across all fan-out sweeps
  function automatic int ci_width(input int fo, input int p, input int z);
    return $clog2(fo * p / z);
  endfunction

  // Seed vector: one clog2(p/z)-bit start offset per lane per sweep
  function automatic int seed_width(input int fo, input int p, input int z);
    return $clog2(p / z) * fo * z;
  endfunction

  // Number of load words needed to fill the seed
  function automatic int nwords(input int seed_w, input int load_w);
    return (seed_w + load_w - 1) / load_w;
  endfunction

  // Sweep number width; kept at least 1 bit so the port always exists
  function automatic int sw_width(input int fo);
    return (fo > 1) ? $clog2(fo) : 1;
  endfunction

  // Word counter width; at least 1 bit
  function automatic int wc_width(input int nw);
    return (nw > 1) ? $clog2(nw) : 1;
  endfunction

endpackage

// File: rtl/interleaver_sequencer_if.sv
// Seed-load stream and cycle-index stream between the sequencer and its neighbours.
interface interleaver_sequencer_if #(
  parameter int LOAD_W = 16,
  parameter int CI_W   = 3,
  parameter int SW_W   = 1
);

  logic              seed_in_valid;
  logic [LOAD_W-1:0] seed_in_data;
  logic              seed_in_ready;

  logic              cycle_valid;
  logic              cycle_ready;
  logic [CI_W-1:0]   cycle_index;
  logic [SW_W-1:0]   sweep_num;
  logic              last_cycle;

  // Sequencer side
  modport master (
    input  seed_in_valid, seed_in_data, cycle_ready,
    output seed_in_ready, cycle_valid, cycle_index, sweep_num, last_cycle
  );

  // Environment side: seed source and index consumer
  modport slave (
    output seed_in_valid, seed_in_data, cycle_ready,
    input  seed_in_ready, cycle_valid, cycle_index, sweep_num, last_cycle
  );

endinterface

// File: rtl/interleaver_seed_reg.sv
// Word-addressed seed register: words land at successive LOAD_W slices of the seed.
module interleaver_seed_reg
  import interleaver_sequencer_pkg::*;
#(
  parameter int SEED_W = 32,
  parameter int LOAD_W = 16,
  parameter int NWORDS = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_cnt,
  input  logic              wr_en,
  input  logic [LOAD_W-1:0] wr_data,
  output logic [SEED_W-1:0] seed,
  output logic              last_word
);

  localparam int WC_W = wc_width(NWORDS);

  logic [WC_W-1:0] word_cnt;

  assign last_word = (word_cnt == WC_W'(NWORDS - 1));

  // Word pointer: restarts at the beginning of every load, advances per written word
  always_ff @(posedge clk) begin
    if (!reset) begin
      word_cnt <= '0;
    end else if (clear_cnt) begin
      word_cnt <= '0;
    end else if (wr_en) begin
      word_cnt <= word_cnt + WC_W'(1);
    end
  end

  // Seed storage: bits beyond SEED_W in the final word are simply dropped
  always_ff @(posedge clk) begin
    if (!reset) begin
      seed <= '0;
    end else if (wr_en) begin
      for (int b = 0; b < SEED_W; b++) begin
        if ((b / LOAD_W) == int'(word_cnt)) begin
          seed[b] <= wr_data[b % LOAD_W];
        end
      end
    end
  end

endmodule

// File: rtl/interleaver_sequencer.sv
// Sequences one junction pass of the activation interleaver: loads the sweepstart
// seed, then walks cycle_index through every slice under valid/ready flow control.
module interleaver_sequencer
  import interleaver_sequencer_pkg::*;
#(
  parameter int fo     = 2,
  parameter int p      = 32,
  parameter int z      = 8,
  parameter int LOAD_W = 16
) (
  input  logic                                clk,
  input  logic                                reset,
  interleaver_sequencer_if.master             bus,
  input  logic                                seed_load,
  output logic                                seed_loaded,
  output logic [seed_width(fo, p, z)-1:0]     sweepstart,
  input  logic                                start,
  input  logic                                continuous,
  input  logic                                abort,
  output logic                                busy,
  output logic                                done,
  output logic                                err
);

  localparam int CI_W   = ci_width(fo, p, z);
  localparam int SEED_W = seed_width(fo, p, z);
  localparam int NWORDS = nwords(SEED_W, LOAD_W);
  localparam int SW_W   = sw_width(fo);
  localparam logic [CI_W-1:0] LAST_INDEX = CI_W'(fo * p / z - 1);

  seq_state_t      state;
  logic            cycle_valid_r;
  logic [CI_W-1:0] cycle_index_r;
  logic            seed_in_ready_r;
  logic            seed_accept;
  logic            seed_last_word;
  logic            seed_clear;

  assign seed_accept = bus.seed_in_valid && seed_in_ready_r && !abort;
  assign seed_clear  = (state == IDLE) && seed_load;

  interleaver_seed_reg #(
    .SEED_W (SEED_W),
    .LOAD_W (LOAD_W),
    .NWORDS (NWORDS)
  ) u_seed_reg (
    .clk       (clk),
    .reset     (reset),
    .clear_cnt (seed_clear),
    .wr_en     (seed_accept),
    .wr_data   (bus.seed_in_data),
    .seed      (sweepstart),
    .last_word (seed_last_word)
  );

  assign bus.seed_in_ready = seed_in_ready_r;
  assign bus.cycle_valid   = cycle_valid_r;
  assign bus.cycle_index   = cycle_index_r;
  assign bus.last_cycle    = cycle_valid_r && (cycle_index_r == LAST_INDEX);
  assign busy              = (state != IDLE);

  generate
    if (fo > 1) begin : g_sweep
      assign bus.sweep_num = cycle_index_r[CI_W-1 -: SW_W];
    end else begin : g_no_sweep
      assign bus.sweep_num = '0;
    end
  endgenerate

  // Control FSM with registered handshake and status outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state           <= IDLE;
      cycle_valid_r   <= 1'b0;
      cycle_index_r   <= '0;
      seed_in_ready_r <= 1'b0;
      seed_loaded     <= 1'b0;
      done            <= 1'b0;
      err             <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (seed_load) begin
            state           <= LOAD;
            seed_loaded     <= 1'b0;
            seed_in_ready_r <= 1'b1;
          end else if (start) begin
            if (seed_loaded) begin
              state         <= RUN;
              cycle_valid_r <= 1'b1;
              cycle_index_r <= '0;
            end else begin
              err <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (abort) begin
            state           <= IDLE;
            seed_in_ready_r <= 1'b0;
            seed_loaded     <= 1'b0;
          end else if (seed_accept && seed_last_word) begin
            state           <= IDLE;
            seed_in_ready_r <= 1'b0;
            seed_loaded     <= 1'b1;
          end
        end
        RUN: begin
          if (abort) begin
            state         <= IDLE;
            cycle_valid_r <= 1'b0;
            cycle_index_r <= '0;
          end else if (cycle_valid_r && bus.cycle_ready) begin
            if (cycle_index_r == LAST_INDEX) begin
              done <= 1'b1;
              if (continuous) begin
                cycle_index_r <= cycle_index_r + CI_W'(1);
              end else begin
                state         <= IDLE;
                cycle_valid_r <= 1'b0;
                cycle_index_r <= '0;
              end
            end else begin
              cycle_index_r <= cycle_index_r + CI_W'(1);
            end
          end
        end
        default: begin
          state           <= IDLE;
          cycle_valid_r   <= 1'b0;
          cycle_index_r   <= '0;
          seed_in_ready_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_interleaver_sequencer.sv
// Directed self-checking bench for interleaver_sequencer at default parameters.
module tb_interleaver_sequencer;
  import interleaver_sequencer_pkg::*;

  localparam int FO     = 2;
  localparam int P      = 32;
  localparam int Z      = 8;
  localparam int LOAD_W = 16;
  localparam int CI_W   = ci_width(FO, P, Z);
  localparam int SEED_W = seed_width(FO, P, Z);
  localparam int SW_W   = sw_width(FO);

  logic              clk;
  logic              reset;
  logic              seed_load;
  logic              seed_loaded;
  logic [SEED_W-1:0] sweepstart;
  logic              start;
  logic              continuous;
  logic              abort;
  logic              busy;
  logic              done;
  logic              err;

  int checks;
  int passes;
  int fails;

  interleaver_sequencer_if #(.LOAD_W(LOAD_W), .CI_W(CI_W), .SW_W(SW_W)) bus ();

  interleaver_sequencer #(.fo(FO), .p(P), .z(Z), .LOAD_W(LOAD_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .seed_load   (seed_load),
    .seed_loaded (seed_loaded),
    .sweepstart  (sweepstart),
    .start       (start),
    .continuous  (continuous),
    .abort       (abort),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  // Free-running clock, 10 time units per period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and return on the following falling edge
  task automatic applyStimulus();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) passes++;
    else begin
      fails++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic loadSeed(input logic [15:0] w0, input logic [15:0] w1);
    seed_load = 1'b1;
    applyStimulus();
    seed_load = 1'b0;
    bus.seed_in_valid = 1'b1;
    bus.seed_in_data  = w0;
    applyStimulus();
    bus.seed_in_data  = w1;
    applyStimulus();
    bus.seed_in_valid = 1'b0;
  endtask

  initial begin
    int ticks;
    int stall_cnt;
    logic got_done;

    checks = 0;
    passes = 0;
    fails  = 0;
    reset = 1'b0;
    seed_load = 1'b0;
    start = 1'b0;
    continuous = 1'b0;
    abort = 1'b0;
    bus.seed_in_valid = 1'b0;
    bus.seed_in_data  = '0;
    bus.cycle_ready   = 1'b1;

    applyStimulus();
    applyStimulus();
    reset = 1'b1;

    // Reset state
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_valid", bus.cycle_valid, 0);
    checkOutput("rst_index", bus.cycle_index, 0);
    checkOutput("rst_sweepstart", sweepstart, 0);
    checkOutput("rst_seed_loaded", seed_loaded, 0);
    checkOutput("rst_ready", bus.seed_in_ready, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_err", err, 0);

    // Start without a seed
    start = 1'b1;
    applyStimulus();
    start = 1'b0;
    checkOutput("noseed_err", err, 1);
    checkOutput("noseed_busy", busy, 0);
    applyStimulus();
    checkOutput("noseed_err_pulse", err, 0);

    // Seed load
    seed_load = 1'b1;
    applyStimulus();
    seed_load = 1'b0;
    checkOutput("load_ready", bus.seed_in_ready, 1);
    checkOutput("load_busy", busy, 1);
    bus.seed_in_valid = 1'b1;
    bus.seed_in_data  = 16'h2D83;
    applyStimulus();
    checkOutput("load_mid_loaded", seed_loaded, 0);
    bus.seed_in_data  = 16'h8772;
    applyStimulus();
    bus.seed_in_valid = 1'b0;
    checkOutput("load_loaded", seed_loaded, 1);
    checkOutput("load_ready_low", bus.seed_in_ready, 0);
    checkOutput("load_seed", sweepstart, 32'h87722D83);
    checkOutput("load_idle", busy, 0);

    // Full pass, ready always high
    start = 1'b1;
    applyStimulus();
    start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      checkOutput("pass_valid", bus.cycle_valid, 1);
      checkOutput("pass_index", bus.cycle_index, k);
      checkOutput("pass_sweep", bus.sweep_num, k / 4);
      checkOutput("pass_last", bus.last_cycle, (k == 7) ? 1 : 0);
      checkOutput("pass_no_done", done, 0);
      applyStimulus();
    end
    checkOutput("pass_done", done, 1);
    checkOutput("pass_busy_low", busy, 0);
    checkOutput("pass_valid_low", bus.cycle_valid, 0);
    checkOutput("pass_index_zero", bus.cycle_index, 0);
    applyStimulus();
    checkOutput("pass_done_pulse", done, 0);

    // Back-pressure: 4 stall cycles at index 3
    start = 1'b1;
    applyStimulus();
    start = 1'b0;
    ticks = 0;
    stall_cnt = 0;
    got_done = 1'b0;
    while (!got_done && ticks < 40) begin
      if (stall_cnt < 4 && bus.cycle_index == 3) begin
        bus.cycle_ready = 1'b0;
        stall_cnt++;
        checkOutput("bp_hold_index", bus.cycle_index, 3);
        checkOutput("bp_hold_valid", bus.cycle_valid, 1);
      end else begin
        bus.cycle_ready = 1'b1;
      end
      applyStimulus();
      ticks++;
      if (done) got_done = 1'b1;
    end
    bus.cycle_ready = 1'b1;
    checkOutput("bp_done_seen", got_done, 1);
    checkOutput("bp_latency", ticks, 12);
    checkOutput("bp_stalls", stall_cnt, 4);

    // Continuous wrap, then drop continuous
    continuous = 1'b1;
    start = 1'b1;
    applyStimulus();
    start = 1'b0;
    for (int k = 0; k < 6; k++) applyStimulus();
    checkOutput("cont_index6", bus.cycle_index, 6);
    start = 1'b1;
    applyStimulus();
    start = 1'b0;
    checkOutput("cont_index7", bus.cycle_index, 7);
    checkOutput("cont_last", bus.last_cycle, 1);
    checkOutput("cont_start_ignored", err, 0);
    applyStimulus();
    checkOutput("cont_wrap_index", bus.cycle_index, 0);
    checkOutput("cont_wrap_valid", bus.cycle_valid, 1);
    checkOutput("cont_wrap_done", done, 1);
    checkOutput("cont_wrap_busy", busy, 1);
    applyStimulus();
    continuous = 1'b0;
    checkOutput("cont_index1", bus.cycle_index, 1);
    checkOutput("cont_done_pulse", done, 0);
    for (int k = 0; k < 6; k++) applyStimulus();
    checkOutput("cont_final7", bus.cycle_index, 7);
    applyStimulus();
    checkOutput("cont_stop_done", done, 1);
    checkOutput("cont_stop_busy", busy, 0);
    checkOutput("cont_stop_valid", bus.cycle_valid, 0);

    // Abort during RUN at index 5 while the index is being accepted
    start = 1'b1;
    applyStimulus();
    start = 1'b0;
    for (int k = 0; k < 5; k++) applyStimulus();
    checkOutput("abort_at5", bus.cycle_index, 5);
    abort = 1'b1;
    applyStimulus();
    abort = 1'b0;
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_index", bus.cycle_index, 0);
    checkOutput("abort_valid", bus.cycle_valid, 0);
    checkOutput("abort_no_done", done, 0);
    applyStimulus();
    checkOutput("abort_no_done_later", done, 0);

    // Abort during LOAD after one word
    seed_load = 1'b1;
    applyStimulus();
    seed_load = 1'b0;
    bus.seed_in_valid = 1'b1;
    bus.seed_in_data  = 16'h1111;
    applyStimulus();
    bus.seed_in_valid = 1'b0;
    abort = 1'b1;
    applyStimulus();
    abort = 1'b0;
    checkOutput("labort_loaded", seed_loaded, 0);
    checkOutput("labort_busy", busy, 0);
    checkOutput("labort_ready", bus.seed_in_ready, 0);
    checkOutput("labort_partial", sweepstart, 32'h87721111);
    start = 1'b1;
    applyStimulus();
    start = 1'b0;
    checkOutput("labort_start_err", err, 1);
    checkOutput("labort_start_busy", busy, 0);

    // Reset in the middle of a pass
    loadSeed(16'h2D83, 16'h8772);
    checkOutput("reload_seed", sweepstart, 32'h87722D83);
    start = 1'b1;
    applyStimulus();
    start = 1'b0;
    for (int k = 0; k < 4; k++) applyStimulus();
    checkOutput("mrst_at4", bus.cycle_index, 4);
    reset = 1'b0;
    applyStimulus();
    reset = 1'b1;
    checkOutput("mrst_busy", busy, 0);
    checkOutput("mrst_index", bus.cycle_index, 0);
    checkOutput("mrst_valid", bus.cycle_valid, 0);
    checkOutput("mrst_seed", sweepstart, 0);
    checkOutput("mrst_loaded", seed_loaded, 0);
    checkOutput("mrst_done", done, 0);
    start = 1'b1;
    applyStimulus();
    start = 1'b0;
    checkOutput("mrst_start_err", err, 1);
    checkOutput("mrst_start_busy", busy, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
